bullet_pool_hor: RTL

- Multi-slot horizontal bullet generator for the attack phase. Holds NUM_BULLETS independent bullets and spawns one per spawn interval into a free slot.
- Bullets travel left-to-right or right-to-left. The direction is latched per bullet at spawn. All bullets advance on a shared move tick.
- Sits between the LFSR (lane select) and the collision/renderer logic, which consume the flattened per-slot buses.

---
 rtl/bullet_pool_hor_if.sv | 27 ++
 rtl/bullet_pool_hor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bullet_pool_hor_if.sv
// Bundles the run/spawn controls and the flattened per-slot bullet buses
// shared between the bullet pool, the LFSR lane source and the renderer.
interface bullet_pool_hor_if #(
    parameter int NUM_BULLETS = 4
);
    logic                       enable;
    logic                       player_collision;
    logic                       direction;
    logic [1:0]                 lane_sel;
    logic [8*NUM_BULLETS-1:0]   bullet_x;
    logic [7*NUM_BULLETS-1:0]   bullet_y;
    logic [NUM_BULLETS-1:0]     bullet_active;
    logic [3*NUM_BULLETS-1:0]   bullet_color;
    logic                       spawn_dropped;

    // Controller side: drives run/spawn controls, observes the bullet buses.
    modport master (
        output enable, player_collision, direction, lane_sel,
        input  bullet_x, bullet_y, bullet_active, bullet_color, spawn_dropped
    );

    // Bullet pool side.
    modport slave (
        input  enable, player_collision, direction, lane_sel,
        output bullet_x, bullet_y, bullet_active, bullet_color, spawn_dropped
    );
endinterface

// File: rtl/bullet_pool_hor.sv
// Multi-slot horizontal bullet pool. One bullet is spawned per spawn tick
// into the lowest free slot; all active bullets advance on a shared move
// tick and retire when their next step would leave the screen.
// There is no handshake: inputs are level-sampled every clock, outputs are
// registered and valid every cycle (bullet_active qualifies each slot).
module bullet_pool_hor #(
    parameter int          NUM_BULLETS  = 4,
    parameter int          SCREEN_WIDTH = 160,
    parameter int          SPAWN_PERIOD = 25_000_000,
    parameter int          MOVE_PERIOD  = 5_000_000,
    parameter int          STEP         = 1,
    parameter int          LANE0_Y      = 91,
    parameter int          LANE1_Y      = 71,
    parameter int          LANE2_Y      = 81,
    parameter int          LANE3_Y      = 61,
    parameter logic [2:0]  ACTIVE_COLOR = 3'b001,
    parameter logic [2:0]  IDLE_COLOR   = 3'b111
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    bullet_pool_hor_if.slave   bus
);

    localparam int MAX_PERIOD = (SPAWN_PERIOD > MOVE_PERIOD) ? SPAWN_PERIOD : MOVE_PERIOD;
    localparam int CNT_W      = $clog2(MAX_PERIOD);

    localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [CNT_W-1:0] MOVE_LAST  = CNT_W'(MOVE_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Rightward bounds are evaluated in 9 bits so x + STEP never wraps.
    localparam logic [8:0] STEP_9  = 9'(STEP);
    localparam logic [8:0] X_MAX_9 = 9'(SCREEN_WIDTH - 1);
    localparam logic [7:0] STEP_8  = 8'(STEP);
    localparam logic [7:0] X_MAX_8 = 8'(SCREEN_WIDTH - 1);
    localparam logic [6:0] RESET_Y = 7'(LANE1_Y);

    logic                   run;
    logic [CNT_W-1:0]       spawn_cnt;
    logic [CNT_W-1:0]       move_cnt;
    logic                   spawn_tick;
    logic                   move_tick;
    logic [NUM_BULLETS-1:0] active;
    logic [NUM_BULLETS-1:0] alloc_oh;
    logic                   alloc_any;
    logic [6:0]             lane_y;
    logic                   dropped_q;

    assign run        = bus.enable & ~bus.player_collision;
    assign spawn_tick = run && (spawn_cnt == SPAWN_LAST);
    assign move_tick  = run && (move_cnt == MOVE_LAST);

    // Spawn and move timebases: count while running, restart from zero on clear.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            spawn_cnt <= '0;
            move_cnt  <= '0;
        end else if (!run) begin
            spawn_cnt <= '0;
            move_cnt  <= '0;
        end else begin
            spawn_cnt <= (spawn_cnt == SPAWN_LAST) ? '0 : spawn_cnt + CNT_ONE;
            move_cnt  <= (move_cnt == MOVE_LAST) ? '0 : move_cnt + CNT_ONE;
        end
    end

    // Spawn lane y from the externally chosen lane index.
    always_comb begin
        lane_y = 7'(LANE0_Y);
        case (bus.lane_sel)
            2'd0: lane_y = 7'(LANE0_Y);
            2'd1: lane_y = 7'(LANE1_Y);
            2'd2: lane_y = 7'(LANE2_Y);
            2'd3: lane_y = 7'(LANE3_Y);
            default: lane_y = 7'(LANE0_Y);
        endcase
    end

    // Lowest-index free slot, judged on the pre-edge active vector, so a
    // slot retiring on this edge only becomes eligible next cycle.
    always_comb begin
        alloc_oh  = '0;
        alloc_any = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!alloc_any && !active[i]) begin
                alloc_oh[i] = 1'b1;
                alloc_any   = 1'b1;
            end
        end
    end

    // One-cycle pulse when a spawn tick finds the pool full.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= spawn_tick & ~alloc_any;
        end
    end

    assign bus.spawn_dropped = dropped_q;

    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
        logic       act_q;
        logic       dir_q;
        logic [7:0] x_q;
        logic [6:0] y_q;
        logic [2:0] color_q;
        logic [8:0] x_sum;

        assign x_sum = {1'b0, x_q} + STEP_9;

        // Per-slot state: clear on stop, spawn takes priority over movement,
        // colour follows the previous cycle's active flag.
        always_ff @(posedge CLOCK_50 or negedge resetn) begin
            if (!resetn) begin
                act_q   <= 1'b0;
                dir_q   <= 1'b0;
                x_q     <= '0;
                y_q     <= RESET_Y;
                color_q <= IDLE_COLOR;
            end else begin
                color_q <= act_q ? ACTIVE_COLOR : IDLE_COLOR;
                if (!run) begin
                    act_q <= 1'b0;
                    x_q   <= '0;
                end else if (spawn_tick && alloc_oh[i]) begin
                    act_q <= 1'b1;
                    dir_q <= bus.direction;
                    y_q   <= lane_y;
                    x_q   <= bus.direction ? X_MAX_8 : 8'd0;
                end else if (move_tick && act_q) begin
                    if (!dir_q) begin
                        if (x_sum <= X_MAX_9) begin
                            x_q <= x_sum[7:0];
                        end else begin
                            act_q <= 1'b0;
                        end
                    end else begin
                        if (x_q >= STEP_8) begin
                            x_q <= x_q - STEP_8;
                        end else begin
                            act_q <= 1'b0;
                        end
                    end
                end
            end
        end

        assign active[i]                = act_q;
        assign bus.bullet_x[8*i +: 8]   = x_q;
        assign bus.bullet_y[7*i +: 7]   = y_q;
        assign bus.bullet_color[3*i +: 3] = color_q;
    end

    assign bus.bullet_active = active;

endmodule
